// File: rtl/fa_bist_pkg.sv
// Shared definitions for the full-adder BIST checker.
// Holds state encodings, vector count and the golden full-adder function.
package fa_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int NUM_VEC = 8;
    localparam logic [2:0] LAST_IDX = 3'(NUM_VEC - 1);

    // idx = {x, y, c_i}; returns {c_o, sum}
    function automatic logic [1:0] fa_golden(input logic [2:0] idx);
        logic sum;
        logic c_o;
        sum = ^idx;
        c_o = (idx[2] & idx[1]) | (idx[2] & idx[0]) | (idx[1] & idx[0]);
        return {c_o, sum};
    endfunction

endpackage

// File: rtl/fa_bist_golden.sv
// Combinational golden full adder: vector index to expected sum/carry.
// Reusable as a reference model by benches.
module fa_bist_golden
    import fa_bist_pkg::*;
(
    input  logic [2:0] idx_i,
    output logic       exp_sum_o,
    output logic       exp_c_o_o
);

    logic [1:0] gold;

    assign gold      = fa_golden(idx_i);
    assign exp_sum_o = gold[0];
    assign exp_c_o_o = gold[1];

endmodule

// File: rtl/fa_bist_checker.sv
// BIST engine for a single full adder: walks all 8 vectors and counts misses.
// Optional FA_BIST_FIRST_FAIL_EN adds FAIL_VALID/FAIL_VEC first-failure capture.
module fa_bist_checker
    import fa_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SUM,
    input  logic             C_O,
    output logic             X,
    output logic             Y,
    output logic             C_I,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
`ifdef FA_BIST_FIRST_FAIL_EN
    output logic             FAIL_VALID,
    output logic [2:0]       FAIL_VEC,
`endif
    output logic [ERR_W-1:0] ERR_CNT
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    generate
        if (SETTLE_CYCLES < 1) begin : g_bad_settle
            $error("fa_bist_checker: SETTLE_CYCLES must be >= 1");
        end
    endgenerate

    state_e           state_q;
    logic [2:0]       idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic [ERR_W-1:0] err_q;
    logic [ERR_W-1:0] err_d;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic             exp_sum;
    logic             exp_c_o;
    logic             mismatch;

`ifdef FA_BIST_FIRST_FAIL_EN
    logic             fail_valid_q;
    logic [2:0]       fail_vec_q;
`endif

    fa_bist_golden u_golden (
        .idx_i     (idx_q),
        .exp_sum_o (exp_sum),
        .exp_c_o_o (exp_c_o)
    );

    // One error per failing vector, saturating at the counter maximum
    always_comb begin
        mismatch = (SUM != exp_sum) || (C_O != exp_c_o);
        err_d    = err_q;
        if (mismatch && (err_q != ERR_MAX)) begin
            err_d = err_q + 1'b1;
        end
    end

    // Run sequencer: vector index, settle counter, error count and status flags
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            err_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
`ifdef FA_BIST_FIRST_FAIL_EN
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        state_q      <= ST_WAIT;
                        idx_q        <= '0;
                        cnt_q        <= CNT_LOAD;
                        err_q        <= '0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
`ifdef FA_BIST_FIRST_FAIL_EN
                        fail_valid_q <= 1'b0;
                        fail_vec_q   <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_CHECK;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_CHECK: begin
                    err_q <= err_d;
`ifdef FA_BIST_FIRST_FAIL_EN
                    if (mismatch && !fail_valid_q) begin
                        fail_valid_q <= 1'b1;
                        fail_vec_q   <= idx_q;
                    end
`endif
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == '0);
                    end else begin
                        state_q <= ST_WAIT;
                        idx_q   <= idx_q + 1'b1;
                        cnt_q   <= CNT_LOAD;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign X       = idx_q[2];
    assign Y       = idx_q[1];
    assign C_I     = idx_q[0];
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign PASS    = pass_q;
    assign ERR_CNT = err_q;

`ifdef FA_BIST_FIRST_FAIL_EN
    assign FAIL_VALID = fail_valid_q;
    assign FAIL_VEC   = fail_vec_q;
`endif

endmodule
